// File: rtl/alu_share_arb_pkg.sv
// Shared WISC definitions: opcode encodings, flag bit positions and the
// per-opcode flag write mask used by the ALU sharing arbiter.
package alu_share_arb_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LHB    = 4'b1010;
   localparam logic [3:0] OP_LLB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Which architectural flag bits an opcode is allowed to write.
   function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
      logic [2:0] m;
      m = '0;
      case (op)
         OP_ADD, OP_SUB:                 m = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
         default:                        m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, on conflict
// the requester that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11)
         grant = last_grant ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational WISC ALU between two requesters, returns a
// registered result per requester and owns the architectural Z/V/N flags.
//
// state  | meaning
// S_IDLE | waiting for a request; req_ready follows the arbiter grant
// S_EXEC | ALU driven from latched operands, result captured at cycle end
// S_RESP | response held on resp_valid[owner] until resp_ready[owner]
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int FLAG_REQ = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [3:0]        req0_opcode,
   input  logic [3:0]        req1_opcode,
   input  logic [DATA_W-1:0] req0_in1,
   input  logic [DATA_W-1:0] req1_in1,
   input  logic [DATA_W-1:0] req0_in2,
   input  logic [DATA_W-1:0] req1_in2,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [2:0]        alu_flag,
   output logic [1:0]        resp_valid,
   input  logic [1:0]        resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [2:0]        resp_flag,
   output logic [2:0]        flag_reg,
   output logic              busy
);

   localparam logic FLAG_OWNER = 1'(FLAG_REQ);

   state_t            state;
   logic              last_grant;
   logic [3:0]        op_q;
   logic [DATA_W-1:0] in1_q;
   logic [DATA_W-1:0] in2_q;
   logic [1:0]        grant;
   logic [2:0]        wr_mask;

   rr_arb2 u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Ready is forced low during reset so nothing looks accepted then.
   assign req_ready  = (state == S_IDLE && !rst) ? grant : 2'b00;
   assign alu_in1    = in1_q;
   assign alu_in2    = in2_q;
   assign alu_opcode = op_q;
   assign busy       = (state != S_IDLE);
   assign wr_mask    = flag_wr_mask(op_q);

   // last_grant doubles as the owner of the in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         op_q       <= '0;
         in1_q      <= '0;
         in2_q      <= '0;
         resp_data  <= '0;
         resp_flag  <= '0;
         flag_reg   <= '0;
         resp_valid <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant != 2'b00) begin
                  op_q       <= grant[1] ? req1_opcode : req0_opcode;
                  in1_q      <= grant[1] ? req1_in1    : req0_in1;
                  in2_q      <= grant[1] ? req1_in2    : req0_in2;
                  last_grant <= grant[1];
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               resp_data <= alu_out;
               resp_flag <= alu_flag;
               if (last_grant == FLAG_OWNER)
                  flag_reg <= (flag_reg & ~wr_mask) | (alu_flag & wr_mask);
               resp_valid <= last_grant ? 2'b10 : 2'b01;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready[last_grant]) begin
                  resp_valid <= 2'b00;
                  state      <= S_IDLE;
               end
            end
            default: begin
               resp_valid <= 2'b00;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized self-checking bench for alu_share_arb with a behavioural ALU
// model and a transaction-level reference for grants, results and flags.
module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [3:0]        req0_opcode, req1_opcode;
   logic [DATA_W-1:0] req0_in1, req1_in1, req0_in2, req1_in2;
   logic [DATA_W-1:0] alu_in1, alu_in2;
   logic [3:0]        alu_opcode;
   logic [DATA_W-1:0] alu_out;
   logic [2:0]        alu_flag;
   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic [2:0]        resp_flag;
   logic [2:0]        flag_reg;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic       flag_ovr_en = 1'b0;
   logic [2:0] flag_ovr    = 3'b000;
   logic       model_last;
   logic [2:0] model_flag;

   alu_share_arb #(.DATA_W(DATA_W), .FLAG_REQ(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req0_opcode (req0_opcode),
      .req1_opcode (req1_opcode),
      .req0_in1    (req0_in1),
      .req1_in1    (req1_in1),
      .req0_in2    (req0_in2),
      .req1_in2    (req1_in2),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_opcode  (alu_opcode),
      .alu_out     (alu_out),
      .alu_flag    (alu_flag),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_flag   (resp_flag),
      .flag_reg    (flag_reg),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int s;
      logic [31:0] r;
      case (op)
         OP_ADD, OP_SUB: begin
            s = (op == OP_ADD) ? int'($signed(a)) + int'($signed(b))
                               : int'($signed(a)) - int'($signed(b));
            if (s > 32767)       return 16'h7FFF;
            else if (s < -32768) return 16'h8000;
            else                 return s[15:0];
         end
         OP_XOR: return a ^ b;
         OP_SLL: return a << b[3:0];
         OP_SRA: return 16'($signed(a) >>> b[3:0]);
         OP_ROR: begin
            r = {a, a} >> b[3:0];
            return r[15:0];
         end
         default: return a + ~b;
      endcase
   endfunction

   function automatic logic [2:0] flag_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      return {^a[7:0], ^b[7:0], op[0] ^ a[15]};
   endfunction

   function automatic logic [2:0] ref_mask(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 3'b111;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
      return 3'b000;
   endfunction

   always_comb begin
      alu_out  = alu_fn(alu_opcode, alu_in1, alu_in2);
      alu_flag = flag_ovr_en ? flag_ovr : flag_fn(alu_opcode, alu_in1, alu_in2);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      req_valid  = 2'b11;
      resp_ready = 2'b00;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_flag_reg", 32'(flag_reg), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_alu_in1", 32'(alu_in1), 32'd0);
      req_valid = 2'b00;
      rst = 1'b0;
      model_last = 1'b1;
      model_flag = 3'b000;
   endtask

   task automatic do_txn(input logic [1:0] v,
                         input logic [3:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [3:0] o1, input logic [15:0] a1, input logic [15:0] b1,
                         input int hold);
      logic g;
      logic [1:0] oh;
      logic [3:0] eo;
      logic [15:0] ea, eb, ed;
      logic [2:0] ef, m;
      @(negedge clk);
      req_valid = v;
      req0_opcode = o0; req0_in1 = a0; req0_in2 = b0;
      req1_opcode = o1; req1_in1 = a1; req1_in2 = b1;
      g  = (v == 2'b11) ? ~model_last : v[1];
      oh = g ? 2'b10 : 2'b01;
      eo = g ? o1 : o0;
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      #1;
      chk("idle_req_ready", 32'(req_ready), 32'(oh));
      chk("idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      model_last = g;
      @(negedge clk);
      req_valid   = 2'($urandom);
      req0_opcode = 4'($urandom); req0_in1 = 16'($urandom); req0_in2 = 16'($urandom);
      req1_opcode = 4'($urandom); req1_in1 = 16'($urandom); req1_in2 = 16'($urandom);
      #1;
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("exec_resp_valid", 32'(resp_valid), 32'd0);
      chk("exec_alu_op", {eo, ea, 12'd0} >> 12, {alu_opcode, alu_in1, 12'd0} >> 12);
      chk("exec_alu_in2", 32'(alu_in2), 32'(eb));
      ed = alu_fn(eo, ea, eb);
      ef = flag_ovr_en ? flag_ovr : flag_fn(eo, ea, eb);
      if (!g) begin
         m = ref_mask(eo);
         model_flag = (model_flag & ~m) | (ef & m);
      end
      resp_ready = ~oh;
      @(negedge clk);
      #1;
      chk("resp_valid", 32'(resp_valid), 32'(oh));
      chk("resp_data", 32'(resp_data), 32'(ed));
      chk("resp_flag", 32'(resp_flag), 32'(ef));
      chk("flag_reg", 32'(flag_reg), 32'(model_flag));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         #1;
         chk("hold_resp_valid", 32'(resp_valid), 32'(oh));
         chk("hold_resp_data", 32'(resp_data), 32'(ed));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = oh | (2'($urandom) & ~oh);
      @(posedge clk);
      #1;
      chk("done_resp_valid", 32'(resp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      resp_ready = 2'b00;
      req_valid  = 2'b00;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      req_valid = 0; resp_ready = 0; rst = 1'b1;
      req0_opcode = 0; req0_in1 = 0; req0_in2 = 0;
      req1_opcode = 0; req1_in1 = 0; req1_in2 = 0;
      @(negedge clk);
      apply_reset();

      flag_ovr_en = 1'b1;
      flag_ovr = 3'b010;
      do_txn(2'b01, OP_ADD, 16'h7FFF, 16'h0001, OP_ADD, 16'h0, 16'h0, 0);
      chk("single_add_flag", 32'(flag_reg), 32'h2);
      chk("single_add_data", 32'(resp_data), 32'h7FFF);

      flag_ovr = 3'b101;
      do_txn(2'b01, OP_SUB, 16'h0003, 16'h0003, OP_ADD, 16'h0, 16'h0, 0);
      flag_ovr = 3'b000;
      do_txn(2'b01, OP_XOR, 16'h1234, 16'h00FF, OP_ADD, 16'h0, 16'h0, 0);
      chk("xor_z_only", 32'(flag_reg), 32'h1);

      flag_ovr = 3'b111;
      do_txn(2'b10, OP_ADD, 16'h0, 16'h0, OP_ADD, 16'h1111, 16'h2222, 0);
      chk("nonowner_flag", 32'(flag_reg), 32'h1);

      flag_ovr = 3'b110;
      do_txn(2'b01, OP_HLT, 16'hAAAA, 16'h5555, OP_ADD, 16'h0, 16'h0, 5);

      flag_ovr_en = 1'b0;
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, 4'($urandom), 16'($urandom), 16'($urandom),
                4'($urandom), 16'($urandom), 16'($urandom), 0);

      for (int i = 0; i < 60; i++) begin
         flag_ovr_en = ($urandom_range(0, 3) == 0);
         flag_ovr    = 3'($urandom);
         do_txn(2'($urandom_range(1, 3)), 4'($urandom), 16'($urandom), 16'($urandom),
                4'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
      end

      flag_ovr_en = 1'b1;
      flag_ovr = 3'b111;
      do_txn(2'b01, OP_ADD, 16'h1, 16'h1, OP_ADD, 16'h0, 16'h0, 0);
      chk("pre_rst_flag", 32'(flag_reg), 32'h7);
      @(negedge clk);
      req_valid = 2'b01;
      req0_opcode = OP_ADD; req0_in1 = 16'h0042; req0_in2 = 16'h0001;
      @(posedge clk);
      req_valid = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_flag_reg", 32'(flag_reg), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_last = 1'b1;
      model_flag = 3'b000;
      resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
         chk("post_rst_idle", 32'(busy), 32'd0);
      end
      resp_ready = 2'b00;

      flag_ovr = 3'b101;
      do_txn(2'b11, OP_SUB, 16'h9, 16'h2, OP_ADD, 16'h3, 16'h4, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Sequences and shares the single combinational 16-bit WISC ALU between two requesters: req0 (pipeline execute) and req1 (auxiliary, e.g. address-calc/debug).
- Arbitrates round-robin and drives the ALU from latched operands.
- Captures result and flags into a registered response with valid/ready handshake.
- Owns the architectural flag register (Z, V, N), updated per opcode class.

Parameters:
- DATA_W, 16, ALU operand/result width.
- FLAG_REQ, 0, index of the only requester whose operations may update the flag register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept.
- req0_opcode, req1_opcode  in  4  WISC opcode.
- req0_in1, req1_in1  in  DATA_W  operand 1.
- req0_in2, req1_in2  in  DATA_W  operand 2.
- alu_in1, alu_in2  out  DATA_W  to ALU.
- alu_opcode  out  4  to ALU.
- alu_out  in  DATA_W  ALU result.
- alu_flag  in  3  ALU flags {Z,V,N}: bit2=Z, bit1=V, bit0=N.
- resp_valid  out  2  per-requester response valid.
- resp_ready  in  2  per-requester response accept.
- resp_data  out  DATA_W  latched result, shared by both requesters.
- resp_flag  out  3  latched raw ALU flags for this operation.
- flag_reg  out  3  architectural {Z,V,N}.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1 (req0 wins first conflict), operand/opcode regs=0, resp_data=0, resp_flag=0, flag_reg=0, resp_valid=0, req_ready=0.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: grant = the single valid requester; if both are valid, grant the one != last_grant. req_ready[grant]=1 in IDLE only; req_ready is combinational on req_valid. On accept: latch opcode/in1/in2, last_grant<=grant, go to EXEC.
  - EXEC: one cycle. alu_* outputs are driven from the latched regs (held at latched values in all states, never from live inputs). At the clock edge: resp_data<=alu_out, resp_flag<=alu_flag, apply the flag update, go to RESP.
  - RESP: resp_valid[granted]=1, other bit 0. Held stable until resp_ready[granted]=1, then go to IDLE. resp_ready on the non-granted bit is ignored.
- Latency: accept at cycle t; resp_valid asserted at t+2. flag_reg update visible at t+2.
- Throughput: one operation per 3 cycles minimum. No new accept before the response handshake; a new accept is possible the cycle after it.
- Flag update, only when the granted requester == FLAG_REQ:
  - ADD (0000) / SUB (0001): Z, V, N all written.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; V, N hold.
  - All other opcodes: flag_reg holds.
- Opcodes 1100-1111 (B, BR, PCS, HLT): accepted and sequenced normally; resp_data=alu_out (whatever the ALU returns); flags never updated.
- Requests are sampled only at accept. Deasserting req_valid in EXEC/RESP has no effect.
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and flag_reg=0.
- Width: no arithmetic in this block; data passes through unmodified.

Decomposition:
- Shared package: WISC opcode constants (OP_ADD..OP_HLT) and flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0). The ALU and decoder use the same constants.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (req, last_grant -> grant one-hot). Everything else stays inline.

Test Plan:
- Single request: req0 valid, ADD in1=0x7FFF, in2=0x0001 (ALU model returns 0x7FFF, flags Z=0 V=1 N=0) -> ready at t, resp_valid[0] at t+2, resp_data=0x7FFF, flag_reg=3'b010.
- Contention: both valid every cycle from reset -> grants in order req0, req1, req0, req1. Each response appears only on its own resp_valid bit.
- Flag masking: req0 SUB sets flag_reg=3'b101 (Z=1, V=0, N=1); then req0 XOR with ALU flags 3'b000 -> flag_reg=3'b001 (only Z cleared).
- Non-owner: req1 ADD with ALU flags 3'b111 -> resp_flag=3'b111, flag_reg unchanged.
- Backpressure: resp_ready[0]=0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready=2'b00 throughout. Accept occurs the cycle after resp_ready=1.
- Reset mid-EXEC: assert rst asynchronously -> state IDLE, resp_valid=0, flag_reg=0 immediately, and no stale response after reset is released.
